pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline control block that generates the freeze and flush inputs for the IF, ID, EXE, MEM and WB stage registers. It resolves three conditions:
- register RAW hazards between ID and the EXE/MEM stages;
- taken-branch flushes from EXE;
- multi-cycle data-memory waits, via a request/ready handshake with a timeout.

It sits beside the pipeline datapath, consumes per-stage hazard information, and drives every stage register's control pins.

## Interface
Parameters:
- REG_AW, 4, register-index width
- MEM_TIMEOUT, 64, max memory-wait cycles before abort (≥2)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- id_src1, id_src2  in  REG_AW  source registers of the instruction in ID
- id_two_src  in  1  id_src2 is a real operand
- id_src_valid  in  1  ID holds a valid instruction reading id_src1
- exe_wb_en, exe_mem_read  in  1  EXE instruction writes back / is a load
- exe_dest  in  REG_AW  EXE destination register
- mem_wb_en  in  1  MEM instruction writes back
- mem_dest  in  REG_AW  MEM destination register
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage has an active load/store
- mem_ready  in  1  data memory completes the access this cycle
- freeze_if, freeze_id, freeze_exe, freeze_mem  out  1  hold the named stage register
- flush_if, flush_id, flush_wb  out  1  clear the named stage register to zero
- mem_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
- FSM states: RUN, MEM_WAIT.
- RUN → MEM_WAIT: mem_req=1 and mem_ready=0.
- MEM_WAIT → RUN: mem_ready=1, or the wait counter reaches MEM_TIMEOUT-1.
- Memory stall: asserted in RUN when mem_req && !mem_ready, and in MEM_WAIT when !mem_ready. Effect: freeze_if/id/exe/mem=1, flush_wb=1 (bubble into WB), all other outputs 0.
- Release: the cycle mem_ready=1 drops all freezes. A stall lasting N cycles with ready on cycle N+1 gives exactly N frozen cycles.
- Timeout: forces freezes low and sets mem_err. mem_err stays set until reset.
- Branch flush (no memory stall): branch_taken → flush_if=1, flush_id=1, no freezes. flush_cnt increments once per flush cycle.
- Data hazard (no memory stall, no branch): freeze_if=1, freeze_id=0, flush_id=1 (bubble into EXE).
- Hazard condition: id_src_valid and (id_src1, or id_src2 when id_two_src) equals exe_dest with exe_wb_en, or equals mem_dest with mem_wb_en.
- Priority: memory stall > branch flush > data hazard.
- Branch during a memory stall: deferred. EXE is frozen, so branch_taken remains valid, and the flush is issued on the release cycle.
- Counters: stall_cnt increments on any cycle with freeze_if=1. Both counters saturate at all-ones.

## Timing
- Hazard, branch and RUN-state stall outputs are combinational from inputs and state, visible in the same cycle.
- State, wait counter, mem_err and perf counters update on posedge clk.
- Reset (rst_n low, asynchronous): state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-MEM_WAIT returns to RUN immediately. While reset is held, all outputs are 0.
- Wait counter clears on entry to MEM_WAIT. It increments in MEM_WAIT up to MEM_TIMEOUT-1.

## Configuration
- HAZARD_FWD_EN defined: a forwarding unit exists. The data hazard reduces to load-use only: exe_mem_read && exe_wb_en && source==exe_dest. MEM-stage matches never stall.
- HAZARD_FWD_EN undefined: the full EXE+MEM comparison above is used.

## Structure
- Shared package: FSM state enum (RUN, MEM_WAIT), REG_AW default, and a stage-control struct/bundle type (freeze + flush per stage).
- One sub-module: hazard_detect — purely combinational source/dest comparison, with the HAZARD_FWD_EN selection inside it.
- FSM, counters and priority muxing live in the top.

## Test plan
- id_src1=3, exe_dest=3, exe_wb_en=1, forwarding off → freeze_if=1, flush_id=1, stall_cnt 0→1.
- Same stimulus with HAZARD_FWD_EN, exe_mem_read=0 → no freeze; with exe_mem_read=1 → stall.
- mem_req=1, mem_ready low for 3 cycles then high → freeze_if/id/exe/mem and flush_wb high for exactly 3 cycles, stall_cnt=3.
- branch_taken=1 together with a hazard on id_src2=5 (id_two_src=1) → flush_if=flush_id=1, freeze_if=0, flush_cnt=1.
- mem_ready held low for MEM_TIMEOUT=4 → freezes drop after 4 stalled cycles, mem_err=1 and stays set; rst_n low clears it asynchronously.
- rst_n pulsed low in MEM_WAIT → next cycle in RUN, counters 0, no freeze with mem_req=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the default register-index width and the per-stage control bundle.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // One freeze/flush pin per stage register that this block steers.
  typedef struct packed {
    logic freeze_if;
    logic freeze_id;
    logic freeze_exe;
    logic freeze_mem;
    logic flush_if;
    logic flush_id;
    logic flush_wb;
  } stage_ctrl_t;

  // Nothing held, nothing cleared.
  localparam stage_ctrl_t CTRL_IDLE = '0;

  // Memory stall: hold everything up to MEM and push a bubble into WB.
  localparam stage_ctrl_t CTRL_MEM_STALL = '{
    freeze_if: 1'b1, freeze_id: 1'b1, freeze_exe: 1'b1, freeze_mem: 1'b1,
    flush_if: 1'b0, flush_id: 1'b0, flush_wb: 1'b1};

  // Taken branch: squash the two wrong-path instructions behind EXE.
  localparam stage_ctrl_t CTRL_BRANCH = '{
    freeze_if: 1'b0, freeze_id: 1'b0, freeze_exe: 1'b0, freeze_mem: 1'b0,
    flush_if: 1'b1, flush_id: 1'b1, flush_wb: 1'b0};

  // RAW hazard: hold fetch and insert a bubble into EXE.
  localparam stage_ctrl_t CTRL_HAZARD = '{
    freeze_if: 1'b1, freeze_id: 1'b0, freeze_exe: 1'b0, freeze_mem: 1'b0,
    flush_if: 1'b0, flush_id: 1'b1, flush_wb: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detection between the ID sources and the
// EXE/MEM destinations. Defining HAZARD_FWD_EN assumes a forwarding unit,
// so only a load in EXE feeding ID (load-use) remains a hazard.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_src_valid,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              hazard
);

  logic src1_exe, src2_exe, src1_mem, src2_mem;

  // Raw source/destination matches; src2 only counts when it is a real operand.
  always_comb begin
    src1_exe = (id_src1 == exe_dest);
    src2_exe = id_two_src && (id_src2 == exe_dest);
    src1_mem = (id_src1 == mem_dest);
    src2_mem = id_two_src && (id_src2 == mem_dest);
  end

`ifdef HAZARD_FWD_EN
  // Forwarded results cover everything except a load still in EXE.
  logic unused_fwd;
  assign unused_fwd = ^{mem_wb_en, src1_mem, src2_mem};

  always_comb begin
    hazard = id_src_valid && exe_mem_read && exe_wb_en && (src1_exe || src2_exe);
  end
`else
  // Without forwarding any pending write in EXE or MEM blocks the reader.
  logic unused_fwd;
  assign unused_fwd = exe_mem_read;

  always_comb begin
    hazard = id_src_valid &&
             ((exe_wb_en && (src1_exe || src2_exe)) ||
              (mem_wb_en && (src1_mem || src2_mem)));
  end
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control: memory-wait FSM with timeout, branch flush and
// RAW-hazard stall, prioritised into per-stage freeze/flush pins, plus
// saturating stall/flush performance counters.
// Optional macro: HAZARD_FWD_EN (forwarding present, load-use stalls only).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_src_valid,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_id,
  output logic              freeze_exe,
  output logic              freeze_mem,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_wb,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              timeout;
  logic              mem_stall;
  stage_ctrl_t       ctrl;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_src_valid (id_src_valid),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  // Stall/timeout decode from FSM state and the memory handshake.
  always_comb begin
    timeout   = (state == MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LAST);
    mem_stall = (state == RUN) ? (mem_req && !mem_ready) : (!mem_ready && !timeout);
  end

  // Priority mux: memory stall > branch flush > data hazard; silent in reset.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves ctrl unassigned (which would infer a latch).
    ctrl = CTRL_IDLE;
    if (rst_n) begin
      if (mem_stall)         ctrl = CTRL_MEM_STALL;
      else if (branch_taken) ctrl = CTRL_BRANCH;
      else if (hazard)       ctrl = CTRL_HAZARD;
    end
  end

  assign freeze_if  = ctrl.freeze_if;
  assign freeze_id  = ctrl.freeze_id;
  assign freeze_exe = ctrl.freeze_exe;
  assign freeze_mem = ctrl.freeze_mem;
  assign flush_if   = ctrl.flush_if;
  assign flush_id   = ctrl.flush_id;
  assign flush_wb   = ctrl.flush_wb;

  // Memory-wait FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= RUN;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters: frozen-fetch cycles and branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctrl.freeze_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl.flush_if  && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies one input
// vector per cycle and pushes the reference model's expected response; a
// monitor pops and compares it against the DUT later in the same cycle.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int REG_AW      = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 5;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REG_AW-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic              id_two_src, id_src_valid, exe_wb_en, exe_mem_read;
  logic              mem_wb_en, branch_taken, mem_req, mem_ready;
  logic              freeze_if, freeze_id, freeze_exe, freeze_mem;
  logic              flush_if, flush_id, flush_wb, mem_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_src_valid(id_src_valid), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_exe(freeze_exe),
    .freeze_mem(freeze_mem), .flush_if(flush_if), .flush_id(flush_id),
    .flush_wb(flush_wb), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic [REG_AW-1:0] src1, src2, exe_dest, mem_dest;
    logic             two, valid, exe_wb, exe_rd, mem_wb, br, req, rdy;
  } stim_t;

  // ctrl bit order: freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id, flush_wb
  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic       err;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: what the pipeline "is doing", not how the RTL encodes it.
  bit in_wait  = 0;   // a memory wait is currently open
  int elapsed  = 0;   // stalled cycles spent on the open wait
  bit err_seen = 0;
  int stalls   = 0;   // true, unsaturated counts
  int flushes  = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.src1 = '0; s.src2 = '0; s.exe_dest = '0; s.mem_dest = '0;
    s.two = 0; s.valid = 0; s.exe_wb = 0; s.exe_rd = 0; s.mem_wb = 0;
    s.br = 0; s.req = 0; s.rdy = 0;
    return s;
  endfunction

  function automatic bit model_hazard(input stim_t s);
    logic [REG_AW-1:0] readers[$];
    logic [REG_AW-1:0] writers[$];
    bit hit = 0;
    if (!s.valid) return 0;
    readers.push_back(s.src1);
    if (s.two) readers.push_back(s.src2);
`ifdef HAZARD_FWD_EN
    if (s.exe_wb && s.exe_rd) writers.push_back(s.exe_dest);
`else
    if (s.exe_wb) writers.push_back(s.exe_dest);
    if (s.mem_wb) writers.push_back(s.mem_dest);
`endif
    foreach (readers[i]) foreach (writers[j]) if (readers[i] == writers[j]) hit = 1;
    return hit;
  endfunction

  task automatic apply(input string tag, input stim_t s);
    exp_t e;
    bit   tmo, stall, hz;
    @(negedge clk);
    rst_n = s.rst_n; id_src1 = s.src1; id_src2 = s.src2; id_two_src = s.two;
    id_src_valid = s.valid; exe_wb_en = s.exe_wb; exe_mem_read = s.exe_rd;
    exe_dest = s.exe_dest; mem_wb_en = s.mem_wb; mem_dest = s.mem_dest;
    branch_taken = s.br; mem_req = s.req; mem_ready = s.rdy;
    #1;
    e.tag = tag;
    if (!s.rst_n) begin
      in_wait = 0; elapsed = 0; err_seen = 0; stalls = 0; flushes = 0;
      e.ctrl = '0; e.err = 0; e.sc = 0; e.fc = 0;
    end else begin
      // A wait is abandoned once it has already cost MEM_TIMEOUT stalled cycles.
      tmo   = in_wait && !s.rdy && (elapsed == MEM_TIMEOUT);
      stall = in_wait ? (!s.rdy && !tmo) : (s.req && !s.rdy);
      hz    = model_hazard(s);
      if (stall)     e.ctrl = 7'b1111001;
      else if (s.br) e.ctrl = 7'b0000110;
      else if (hz)   e.ctrl = 7'b1000010;
      else           e.ctrl = 7'b0000000;
      e.err = err_seen;
      e.sc  = (stalls  > CNT_MAX) ? CNT_MAX : stalls;
      e.fc  = (flushes > CNT_MAX) ? CNT_MAX : flushes;
      if (e.ctrl[6]) stalls++;
      if (e.ctrl[2]) flushes++;
      if (tmo) err_seen = 1;
      if (stall) begin in_wait = 1; elapsed++; end
      else begin in_wait = 0; elapsed = 0; end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares each cycle's DUT response with the queued expectation.
  initial begin
    exp_t       e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id, flush_wb};
        n_vec++;
        if (got !== e.ctrl || mem_err !== e.err ||
            int'(stall_cnt) != e.sc || int'(flush_cnt) != e.fc) begin
          n_bad++;
          $display("FAIL vec%0d %s: ctrl got %b want %b, mem_err got %b want %b, stall_cnt got %0d want %0d, flush_cnt got %0d want %0d",
                   n_vec, e.tag, got, e.ctrl, mem_err, e.err, stall_cnt, e.sc, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    // Reset state.
    s = idle(); s.rst_n = 0;
    apply("reset", s);
    apply("reset", s);
    apply("post_reset", idle());

    // RAW hazard on r3 from EXE.
    s = idle(); s.valid = 1; s.src1 = 3; s.exe_dest = 3; s.exe_wb = 1;
    apply("hazard_exe", s);
    s.exe_rd = 1;
    apply("hazard_load", s);
    s = idle(); s.valid = 1; s.src1 = 6; s.mem_dest = 6; s.mem_wb = 1;
    apply("hazard_mem", s);
    apply("after_hazard", idle());

    // Three-cycle memory wait then release.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (3) apply("mem_stall", s);
    s.rdy = 1;
    apply("mem_release", s);
    apply("after_mem", idle());

    // Branch alongside an src2 hazard: branch wins.
    s = idle(); s.br = 1; s.valid = 1; s.two = 1; s.src1 = 1; s.src2 = 5;
    s.exe_dest = 5; s.exe_wb = 1;
    apply("branch_vs_hazard", s);
    apply("after_branch", idle());

    // Branch during memory stall is deferred to the release cycle.
    s = idle(); s.br = 1; s.req = 1; s.rdy = 0;
    repeat (2) apply("branch_in_stall", s);
    s.rdy = 1;
    apply("branch_release", s);

    // Timeout with ready held low.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (6) apply("timeout", s);
    repeat (2) apply("err_sticky", idle());

    // Asynchronous reset in the middle of a wait.
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (2) apply("wait_before_rst", s);
    s.rst_n = 0;
    apply("rst_in_wait", s);
    apply("run_after_rst", idle());

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s.rst_n    = ($urandom_range(0, 199) != 0);
      s.src1     = REG_AW'($urandom_range(0, 3));
      s.src2     = REG_AW'($urandom_range(0, 3));
      s.exe_dest = REG_AW'($urandom_range(0, 3));
      s.mem_dest = REG_AW'($urandom_range(0, 3));
      s.two      = $urandom_range(0, 1);
      s.valid    = $urandom_range(0, 3) != 0;
      s.exe_wb   = $urandom_range(0, 1);
      s.exe_rd   = $urandom_range(0, 1);
      s.mem_wb   = $urandom_range(0, 1);
      s.br       = $urandom_range(0, 4) == 0;
      s.req      = $urandom_range(0, 2) == 0;
      s.rdy      = $urandom_range(0, 2) == 0;
      apply("random", s);
    end

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
